// File: rtl/ecc_pkg.sv
// Shared ECC constants and helpers for the Hamming+overall-parity encoder/decoder pair.
package ecc_pkg;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SBE  = 2'b01;
  localparam logic [1:0] ERR_DBE  = 2'b10;
  localparam logic [1:0] ERR_CBE  = 2'b11;

  // Hamming check bits plus one overall parity bit for a given data width.
  function automatic int unsigned ecc_par_w(input int unsigned data_w);
    int unsigned res;
    res = 0;
    for (int unsigned h = 1; h < 16; h++) begin
      if (res == 0 && (32'd1 << h) >= data_w + h + 1) res = h + 1;
    end
    return res;
  endfunction

  // Codeword position of data bit idx: the idx-th non-power-of-two position from 3.
  function automatic int unsigned ecc_data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 3; p < 256; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_syndrome_gen.sv
// Combinational syndrome generator; with zero check bits in, the low bits are the encoder's parity.
module ecc_syndrome_gen
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PAR_W  = ecc_par_w(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [PAR_W-1:0]  i_parity,
  output logic [PAR_W-1:0]  o_syndrome
);

  localparam int unsigned HAM_W = PAR_W - 1;

  logic [HAM_W-1:0] w_pos [DATA_W];

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
    localparam int unsigned Pos = ecc_data_pos(gi);
    assign w_pos[gi] = HAM_W'(Pos);
  end

  always_comb begin
    o_syndrome = '0;
    for (int j = 0; j < HAM_W; j++) begin
      o_syndrome[j] = i_parity[j];
      for (int i = 0; i < DATA_W; i++) begin
        if (w_pos[i][j]) o_syndrome[j] = o_syndrome[j] ^ i_data[i];
      end
    end
    o_syndrome[PAR_W-1] = ^{i_data, i_parity};
  end

endmodule

// File: rtl/ecc_dec_pipe.sv
// Two-stage SEC-DED decoder with saturating error counters and first-error capture.
module ecc_dec_pipe
  import ecc_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W  = ecc_par_w(DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] dec_in,
  input  logic [PAR_W-1:0]  parity_in,
  input  logic              ecc_en,
  input  logic              cnt_clr,
  output logic              valid_out,
  output logic [DATA_W-1:0] dec_out,
  output logic [1:0]        error,
  output logic [CNT_W-1:0]  cnt_sbe,
  output logic [CNT_W-1:0]  cnt_dbe,
  output logic [CNT_W-1:0]  cnt_cbe,
  output logic              cap_vld,
  output logic [PAR_W-1:0]  cap_syndrome,
  output logic [DATA_W-1:0] cap_data
);

  localparam int unsigned HAM_W = PAR_W - 1;

  logic [PAR_W-1:0]  w_syn;
  logic              r_s1_vld;
  logic              r_s1_ecc_en;
  logic [DATA_W-1:0] r_s1_data;
  logic [PAR_W-1:0]  r_s1_syn;

  ecc_syndrome_gen #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W)
  ) u_syn (
    .i_data     (dec_in),
    .i_parity   (parity_in),
    .o_syndrome (w_syn)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld    <= 1'b0;
      r_s1_ecc_en <= 1'b0;
      r_s1_data   <= '0;
      r_s1_syn    <= '0;
    end else begin
      r_s1_vld    <= valid_in;
      r_s1_ecc_en <= ecc_en;
      r_s1_data   <= dec_in;
      r_s1_syn    <= w_syn;
    end
  end

  logic [HAM_W-1:0]  w_low;
  logic              w_ovr;
  logic [DATA_W-1:0] w_hit;
  logic              w_low_pow2;
  logic [1:0]        w_err;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_corr;

  assign w_low      = r_s1_syn[HAM_W-1:0];
  assign w_ovr      = r_s1_syn[PAR_W-1];
  // Zero also counts as "power of two" here: it flags an overall-parity-only error.
  assign w_low_pow2 = (w_low & (w_low - HAM_W'(1))) == '0;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_hit
    localparam int unsigned Pos = ecc_data_pos(gi);
    assign w_hit[gi] = (w_low == HAM_W'(Pos));
  end

  always_comb begin
    w_err = ERR_DBE;
    if (r_s1_syn == '0)  w_err = ERR_NONE;
    else if (!w_ovr)     w_err = ERR_DBE;
    else if (w_low_pow2) w_err = ERR_CBE;
    else if (|w_hit)     w_err = ERR_SBE;
  end

  assign w_mask = (w_err == ERR_SBE) ? w_hit : '0;
  assign w_corr = r_s1_ecc_en ? (r_s1_data ^ w_mask) : r_s1_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out <= 1'b0;
      dec_out   <= '0;
      error     <= ERR_NONE;
    end else begin
      valid_out <= r_s1_vld;
      if (r_s1_vld) begin
        dec_out <= w_corr;
        error   <= w_err;
      end
    end
  end

  // Clear is checked before any stage-2 update so it wins over a same-cycle event.
  always_ff @(posedge clock) begin
    if (reset || cnt_clr) begin
      cnt_sbe      <= '0;
      cnt_dbe      <= '0;
      cnt_cbe      <= '0;
      cap_vld      <= 1'b0;
      cap_syndrome <= '0;
      cap_data     <= '0;
    end else if (r_s1_vld) begin
      if (w_err == ERR_SBE && cnt_sbe != '1) cnt_sbe <= cnt_sbe + CNT_W'(1);
      if (w_err == ERR_DBE && cnt_dbe != '1) cnt_dbe <= cnt_dbe + CNT_W'(1);
      if (w_err == ERR_CBE && cnt_cbe != '1) cnt_cbe <= cnt_cbe + CNT_W'(1);
      if (w_err != ERR_NONE && !cap_vld) begin
        cap_vld      <= 1'b1;
        cap_syndrome <= r_s1_syn;
        cap_data     <= r_s1_data;
      end
    end
  end

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// Randomised and directed check of ecc_dec_pipe (DATA_W=32) against a behavioural model.
module tb_ecc_dec_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] dec_in = '0;
  logic [6:0]  parity_in = '0;
  logic        ecc_en = 1'b1;
  logic        cnt_clr = 1'b0;
  logic        valid_out;
  logic [31:0] dec_out;
  logic [1:0]  error;
  logic [15:0] cnt_sbe, cnt_dbe, cnt_cbe;
  logic        cap_vld;
  logic [6:0]  cap_syndrome;
  logic [31:0] cap_data;

  ecc_dec_pipe #(
    .DATA_W (32),
    .CNT_W  (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_in     (valid_in),
    .dec_in       (dec_in),
    .parity_in    (parity_in),
    .ecc_en       (ecc_en),
    .cnt_clr      (cnt_clr),
    .valid_out    (valid_out),
    .dec_out      (dec_out),
    .error        (error),
    .cnt_sbe      (cnt_sbe),
    .cnt_dbe      (cnt_dbe),
    .cnt_cbe      (cnt_cbe),
    .cap_vld      (cap_vld),
    .cap_syndrome (cap_syndrome),
    .cap_data     (cap_data)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Position of data bit i: count positions 3,5,6,7,9,... skipping powers of two.
  function automatic int spec_pos(input int i);
    int n;
    n = -1;
    for (int p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        n++;
        if (n == i) return p;
      end
    end
    return 0;
  endfunction

  // Low syndrome is the XOR of the positions of all set data bits, XOR low check bits.
  function automatic logic [6:0] model_syn(input logic [31:0] d, input logic [6:0] p);
    int low;
    low = 0;
    for (int i = 0; i < 32; i++) if (d[i]) low = low ^ spec_pos(i);
    low = low ^ int'(p[5:0]);
    return {(^d) ^ (^p), 6'(low)};
  endfunction

  function automatic logic [6:0] encode(input logic [31:0] d);
    logic [6:0] s;
    s = model_syn(d, 7'h00);
    return {s[6] ^ (^s[5:0]), s[5:0]};
  endfunction

  function automatic void classify(input logic [31:0] d, input logic [6:0] p,
                                   output logic [1:0] code, output int idx);
    logic [6:0] s;
    int low;
    s = model_syn(d, p);
    low = int'(s[5:0]);
    idx = -1;
    for (int i = 0; i < 32; i++) if (spec_pos(i) == low) idx = i;
    if (s == 0) code = 2'b00;
    else if (!s[6]) code = 2'b10;
    else if ((low & (low - 1)) == 0) code = 2'b11;
    else if (idx >= 0) code = 2'b01;
    else code = 2'b10;
  endfunction

  // Behavioural reference: two-cycle delay, then classification/count/capture rules.
  logic        m1_vld, m1_en;
  logic [31:0] m1_d;
  logic [6:0]  m1_p;
  logic        m_vout;
  logic [31:0] m_dout;
  logic [1:0]  m_err;
  logic [15:0] m_sbe, m_dbe, m_cbe;
  logic        m_capv;
  logic [6:0]  m_caps;
  logic [31:0] m_capd;

  always @(posedge clock) begin : p_model
    logic [1:0] c;
    int ix;
    if (reset) begin
      m1_vld <= 0; m1_en <= 0; m1_d <= 0; m1_p <= 0;
      m_vout <= 0; m_dout <= 0; m_err <= 0;
      m_sbe <= 0; m_dbe <= 0; m_cbe <= 0;
      m_capv <= 0; m_caps <= 0; m_capd <= 0;
    end else begin
      classify(m1_d, m1_p, c, ix);
      m_vout <= m1_vld;
      if (m1_vld) begin
        m_dout <= (c == 2'b01 && m1_en) ? (m1_d ^ (32'd1 << ix)) : m1_d;
        m_err  <= c;
      end
      if (cnt_clr) begin
        m_sbe <= 0; m_dbe <= 0; m_cbe <= 0;
        m_capv <= 0; m_caps <= 0; m_capd <= 0;
      end else if (m1_vld) begin
        if (c == 2'b01 && m_sbe != 16'hFFFF) m_sbe <= m_sbe + 16'd1;
        if (c == 2'b10 && m_dbe != 16'hFFFF) m_dbe <= m_dbe + 16'd1;
        if (c == 2'b11 && m_cbe != 16'hFFFF) m_cbe <= m_cbe + 16'd1;
        if (c != 2'b00 && !m_capv) begin
          m_capv <= 1'b1;
          m_caps <= model_syn(m1_d, m1_p);
          m_capd <= m1_d;
        end
      end
      m1_vld <= valid_in; m1_en <= ecc_en; m1_d <= dec_in; m1_p <= parity_in;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("valid_out", 64'(valid_out), 64'(m_vout));
      chk("dec_out", 64'(dec_out), 64'(m_dout));
      chk("error", 64'(error), 64'(m_err));
      chk("cnt_sbe", 64'(cnt_sbe), 64'(m_sbe));
      chk("cnt_dbe", 64'(cnt_dbe), 64'(m_dbe));
      chk("cnt_cbe", 64'(cnt_cbe), 64'(m_cbe));
      chk("cap_vld", 64'(cap_vld), 64'(m_capv));
      chk("cap", 64'({cap_syndrome, cap_data}), 64'({m_caps, m_capd}));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [6:0] p, input logic en);
    valid_in = 1'b1; dec_in = d; parity_in = p; ecc_en = en;
    step();
    valid_in = 1'b0;
    step();
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  // Valid codeword for d with nflip distinct bits of the 39-bit codeword flipped.
  task automatic gen_word(input int nflip, output logic [31:0] d, output logic [6:0] p);
    logic [38:0] cw;
    int b1, b2;
    d  = $urandom;
    cw = {encode(d), d};
    b1 = $urandom_range(0, 38);
    b2 = (b1 + $urandom_range(1, 38)) % 39;
    if (nflip >= 1) cw[b1] = ~cw[b1];
    if (nflip >= 2) cw[b2] = ~cw[b2];
    d = cw[31:0];
    p = cw[38:32];
  endtask

  initial begin
    logic [31:0] d;
    logic [6:0]  p;

    chk("model_syn_bit0", 64'(model_syn(32'h1, 7'h00)), 64'h43);
    chk("model_syn_bit31", 64'(model_syn(32'h8000_0000, 7'h00)), 64'h66);
    chk("model_syn_dbe", 64'(model_syn(32'h3, 7'h00)), 64'h06);

    step();
    step();
    chk_en = 1'b1;
    chk("rst_valid_out", 64'(valid_out), 64'h0);
    chk("rst_counters", 64'({cnt_sbe, cnt_dbe, cnt_cbe}), 64'h0);
    chk("rst_cap", 64'({cap_vld, cap_syndrome, cap_data}), 64'h0);
    reset = 1'b0;
    step();

    send(32'h0, 7'h00, 1'b1);
    chk("clean_vout", 64'(valid_out), 64'h1);
    chk("clean_dout", 64'(dec_out), 64'h0);
    chk("clean_err", 64'(error), 64'h0);
    chk("clean_cnt", 64'({cnt_sbe, cnt_dbe, cnt_cbe, 15'h0, cap_vld}), 64'h0);

    send(32'h1, 7'h00, 1'b1);
    chk("sbe_dout", 64'(dec_out), 64'h0);
    chk("sbe_err", 64'(error), 64'h1);
    chk("sbe_cnt", 64'(cnt_sbe), 64'h1);
    chk("sbe_capsyn", 64'(cap_syndrome), 64'h43);
    send(32'h1, 7'h00, 1'b0);
    chk("sbe_noen_dout", 64'(dec_out), 64'h1);
    chk("sbe_noen_err", 64'(error), 64'h1);

    clr();
    send(32'h3, 7'h00, 1'b1);
    chk("dbe_err", 64'(error), 64'h2);
    chk("dbe_dout", 64'(dec_out), 64'h3);
    chk("dbe_cnt", 64'(cnt_dbe), 64'h1);
    chk("dbe_capsyn", 64'(cap_syndrome), 64'h06);

    send(32'h0, 7'h01, 1'b1);
    chk("cbe_err", 64'(error), 64'h3);
    chk("cbe_dout", 64'(dec_out), 64'h0);
    chk("cbe_cnt", 64'(cnt_cbe), 64'h1);
    step();
    chk("hold_vout", 64'(valid_out), 64'h0);
    chk("hold_dout_err", 64'({dec_out, error}), 64'h3);

    // Reset with words in flight: nothing may emerge or be counted.
    clr();
    valid_in = 1'b1; dec_in = 32'h3; parity_in = 7'h00;
    step();
    dec_in = 32'h0; parity_in = 7'h01; reset = 1'b1;
    step();
    chk("midrst_vout", 64'(valid_out), 64'h0);
    reset = 1'b0; valid_in = 1'b0;
    step();
    chk("midrst_vout2", 64'(valid_out), 64'h0);
    step();
    chk("midrst_cnt", 64'({cnt_sbe, cnt_dbe, cnt_cbe}), 64'h0);

    // Counter saturation, then clear racing a stage-2 error.
    valid_in = 1'b1;
    ecc_en = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      d = $urandom;
      p = encode(d);
      d[$urandom_range(0, 31)] ^= 1'b1;
      dec_in = d; parity_in = p;
      step();
    end
    chk("sat_sbe", 64'(cnt_sbe), 64'hFFFF);
    valid_in = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_win_sbe", 64'(cnt_sbe), 64'h0);
    chk("clr_win_capv", 64'(cap_vld), 64'h0);

    // Randomised traffic with occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ecc_en   = ($urandom_range(0, 4) != 0);
      cnt_clr  = ($urandom_range(0, 63) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      gen_word($urandom_range(0, 2), d, p);
      if ($urandom_range(0, 7) == 0) p = 7'($urandom);
      dec_in = d; parity_in = p;
      step();
    end
    reset = 1'b0; valid_in = 1'b0; cnt_clr = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_dec_pipe.md
ECC_DEC_PIPE -- requirements
Module: ecc_dec_pipe

Interface
REQ-001 Parameter DATA_W, default 32, data width; legal values 16, 32, 64.
REQ-002 Parameter CNT_W, default 16, width of each error counter.
REQ-003 Derived constant PAR_W = Hamming bits + 1 overall parity: 6 for 16, 7 for 32, 8 for 64.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 valid_in  input  1  dec_in/parity_in qualify this cycle.
REQ-007 dec_in  input  DATA_W  data word to check.
REQ-008 parity_in  input  PAR_W  stored check bits; MSB is overall parity.
REQ-009 ecc_en  input  1  1 = apply correction mask, 0 = pass data uncorrected (status still reported).
REQ-010 cnt_clr  input  1  clears counters and capture registers.
REQ-011 valid_out  output  1  dec_out/error valid.
REQ-012 dec_out  output  DATA_W  corrected data.
REQ-013 error  output  2  00 none, 01 single data bit corrected, 10 double/uncorrectable, 11 single check-bit error.
REQ-014 cnt_sbe, cnt_dbe, cnt_cbe  output  CNT_W each  counts of codes 01, 10, 11.
REQ-015 cap_vld  output  1  first-error capture holds data.
REQ-016 cap_syndrome  output  PAR_W; cap_data  output  DATA_W  syndrome and raw dec_in of first error after clear.

Function
REQ-017 Data bit i SHALL map to the i-th non-power-of-two Hamming position, counting from 3; low syndrome bits = XOR of data bits covering each position, XOR low parity_in bits.
REQ-018 Overall syndrome bit SHALL be XOR of all dec_in bits, all parity_in bits.
REQ-019 For DATA_W=32 encoding SHALL be bit-identical to the existing 32/7 ECC (data 0 -> syndrome 7'b1000011, data 31 -> 7'b1100110).
REQ-020 Classification: syndrome all zero -> 00; overall=1 and low maps to valid data position -> 01; overall=1 and low zero or power of two -> 11; overall=0 and low nonzero, or overall=1 and low beyond last data position -> 10.
REQ-021 Mask SHALL be nonzero only for code 01; codes 10/11 SHALL pass dec_in unmodified.
REQ-022 Pipeline: stage 1 registers dec_in, ecc_en, syndrome, valid; stage 2 registers dec_out, error, valid_out; latency exactly 2 cycles, throughput 1 word/cycle, no backpressure.
REQ-023 When valid_in=0, stage registers SHALL load but valid_out=0 two cycles later; counters and capture SHALL not change.
REQ-024 dec_out/error SHALL hold their last valid values while valid_out=0.
REQ-025 Counters SHALL increment by 1 on stage-2 acceptance of matching code and saturate at all-ones.
REQ-026 cnt_clr and increment same cycle: clear wins, counter = 0.
REQ-027 Capture SHALL load on first stage-2 nonzero error while cap_vld=0, set cap_vld; later errors SHALL not overwrite; cnt_clr clears cap_vld, cap_syndrome, cap_data; clear wins over simultaneous capture.

Reset
REQ-028 reset SHALL zero all pipeline registers, valid_out, dec_out, error, counters, cap_vld, cap_syndrome, cap_data.
REQ-029 Reset mid-stream SHALL discard in-flight words: valid_out=0 the cycle after reset, with no count.

Structure
REQ-030 Error-code constants and PAR_W derivation function SHALL live in shared package ecc_pkg, used also by the encoder.
REQ-031 Syndrome generation SHALL be sub-module ecc_syndrome_gen (combinational, parametrised DATA_W), reusable by the encoder.

Verification (DATA_W=32)
REQ-032 dec_in=0x00000000, parity_in=0 -> 2 cycles later dec_out=0x00000000, error=00, no count.
REQ-033 dec_in=0x00000001, parity_in=0, ecc_en=1 -> dec_out=0x00000000, error=01, cnt_sbe=1, cap_syndrome=7'b1000011; same with ecc_en=0 -> dec_out=0x00000001, error=01.
REQ-034 dec_in=0x00000003, parity_in=0 -> syndrome 7'b0000110, error=10, dec_out=0x00000003, cnt_dbe=1.
REQ-035 dec_in=0, parity_in=7'h01 -> error=11, dec_out=0, cnt_cbe=1.
REQ-036 65540 consecutive single errors -> cnt_sbe=16'hFFFF; cnt_clr with concurrent error -> cnt_sbe=0, cap_vld=0.
REQ-037 Reset asserted with two valid words in flight -> no valid_out, all counters remain 0.
